// File: rtl/mask_prefix_pipe.sv
// Pipelined Kogge-Stone prefix popcount with valid/ready flow control and a global stall.
// Define PREFIX_CARRY_EN to build the cross-beat running carry (cleared by in_last).
module mask_prefix_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned PSUM_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_mask,
  input  logic                    in_mode,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*PSUM_W-1:0] out_psum,
  output logic [PSUM_W-1:0]       out_total,
  output logic                    out_last
);

  localparam int unsigned LEVELS = $clog2(WIDTH);
  // A lane count never exceeds WIDTH, so the tree only needs LEVELS+1 bits.
  localparam int unsigned CNT_W  = LEVELS + 1;

  logic adv;

  // Rank 0 captures the raw beat; rank r holds the tree after level r-1.
  logic [LEVELS:0]  valid_q, valid_d;
  logic [LEVELS:0]  mode_q, mode_d;
  logic [LEVELS:0]  last_q, last_d;
  logic [WIDTH-1:0] mask_q [LEVELS+1];
  logic [WIDTH-1:0] mask_d [LEVELS+1];
  logic [CNT_W-1:0] sum_q  [LEVELS+1][WIDTH];
  logic [CNT_W-1:0] sum_d  [LEVELS+1][WIDTH];

  logic                    out_valid_q, out_valid_d;
  logic [WIDTH*PSUM_W-1:0] out_psum_q, out_psum_d;
  logic [PSUM_W-1:0]       out_total_q, out_total_d;
  logic                    out_last_q, out_last_d;

  logic [PSUM_W-1:0] carry;
  logic [PSUM_W-1:0] beat_total;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && !reset;

  always_comb begin
    valid_d[0] = in_valid;
    mode_d[0]  = in_mode;
    last_d[0]  = in_last;
    mask_d[0]  = in_mask;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum_d[0][i] = CNT_W'(in_mask[i]);
    end
    for (int r = 1; r <= int'(LEVELS); r++) begin
      valid_d[r] = valid_q[r-1];
      mode_d[r]  = mode_q[r-1];
      last_d[r]  = last_q[r-1];
      mask_d[r]  = mask_q[r-1];
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (i >= (1 << (r - 1))) begin
          sum_d[r][i] = sum_q[r-1][i] + sum_q[r-1][i - (1 << (r - 1))];
        end else begin
          sum_d[r][i] = sum_q[r-1][i];
        end
      end
    end
  end

`ifdef PREFIX_CARRY_EN
  logic [PSUM_W-1:0] carry_q, carry_d;

  assign carry = carry_q;

  always_comb begin
    carry_d = carry_q;
    if (valid_q[LEVELS]) begin
      carry_d = last_q[LEVELS] ? '0 : beat_total;
    end
  end
`else
  assign carry = '0;
`endif

  assign beat_total = carry + PSUM_W'(sum_q[LEVELS][WIDTH-1]);

  // Exclusive result is the inclusive one minus the lane's own bit.
  always_comb begin
    out_valid_d = valid_q[LEVELS];
    out_psum_d  = out_psum_q;
    out_total_d = out_total_q;
    out_last_d  = out_last_q;
    if (valid_q[LEVELS]) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        out_psum_d[i*PSUM_W +: PSUM_W] = carry + PSUM_W'(sum_q[LEVELS][i])
            - (mode_q[LEVELS] ? PSUM_W'(mask_q[LEVELS][i]) : PSUM_W'(0));
      end
      out_total_d = beat_total;
      out_last_d  = last_q[LEVELS];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      out_valid_q <= 1'b0;
      out_psum_q  <= '0;
      out_total_q <= '0;
      out_last_q  <= 1'b0;
`ifdef PREFIX_CARRY_EN
      carry_q     <= '0;
`endif
    end else if (adv) begin
      valid_q     <= valid_d;
      mode_q      <= mode_d;
      last_q      <= last_d;
      mask_q      <= mask_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_psum_q  <= out_psum_d;
      out_total_q <= out_total_d;
      out_last_q  <= out_last_d;
`ifdef PREFIX_CARRY_EN
      carry_q     <= carry_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_psum  = out_psum_q;
  assign out_total = out_total_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mask_prefix_pipe.sv
// Bench for mask_prefix_pipe: a 32-bit-sum and a 6-bit-sum instance share stimulus and are
// checked against a counting reference model through per-instance scoreboards.
module tb_mask_prefix_pipe;

  localparam int unsigned W   = 32;
  localparam int unsigned PW  = 32;
  localparam int unsigned PW6 = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_mode, in_last, out_ready;
  logic [W-1:0]    in_mask;
  logic            in_ready, out_valid, out_last;
  logic [W*PW-1:0] out_psum;
  logic [PW-1:0]   out_total;
  logic             in_ready6, out_valid6, out_last6;
  logic [W*PW6-1:0] out_psum6;
  logic [PW6-1:0]   out_total6;

  always #5 clk = ~clk;

  mask_prefix_pipe #(.WIDTH(W), .PSUM_W(PW)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .in_mode(in_mode), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_psum(out_psum), .out_total(out_total), .out_last(out_last)
  );

  mask_prefix_pipe #(.WIDTH(W), .PSUM_W(PW6)) u_dut6 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready6), .in_mask(in_mask),
    .in_mode(in_mode), .in_last(in_last), .out_valid(out_valid6), .out_ready(out_ready),
    .out_psum(out_psum6), .out_total(out_total6), .out_last(out_last6)
  );

  int n_vec = 0;
  int n_mis = 0;
  bit acc   = 1'b0;

  logic [W*32-1:0] q_p[$], q6_p[$];
  int unsigned     q_t[$], q6_t[$];
  bit              q_l[$], q6_l[$];
  int unsigned     m_carry = 0, m_carry6 = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count set bits lane by lane on top of the carry in.
  task automatic model_beat(input logic [W-1:0] m, input logic md, input logic ls,
                            inout int unsigned carry, output logic [W*32-1:0] p,
                            output int unsigned tot);
    int unsigned cnt;
    int unsigned cin;
    cnt = 0;
`ifdef PREFIX_CARRY_EN
    cin = carry;
`else
    cin = 0;
`endif
    for (int i = 0; i < int'(W); i++) begin
      if (md) begin
        p[i*32 +: 32] = cin + cnt;
        cnt += m[i];
      end else begin
        cnt += m[i];
        p[i*32 +: 32] = cin + cnt;
      end
    end
    tot   = cin + cnt;
    carry = ls ? 0 : tot;
  endtask

  task automatic step();
    logic [W*32-1:0] p;
    int unsigned     t;
    @(negedge clk);
    acc = 1'b0;
    cmp("in_ready", 32'(in_ready), 32'(!reset && (!out_valid || out_ready)));
    cmp("in_ready6", 32'(in_ready6), 32'(!reset && (!out_valid6 || out_ready)));
    if (reset) begin
      q_p.delete(); q_t.delete(); q_l.delete();
      q6_p.delete(); q6_t.delete(); q6_l.delete();
      m_carry  = 0;
      m_carry6 = 0;
    end else begin
      if (out_valid) begin
        if (q_p.size() == 0) begin
          cmp("out_valid_unexpected", 32'(out_valid), 32'd0);
        end else begin
          p = q_p[0];
          for (int i = 0; i < int'(W); i++)
            cmp($sformatf("psum[%0d]", i), out_psum[i*32 +: 32], p[i*32 +: 32]);
          cmp("total", out_total, q_t[0]);
          cmp("last", 32'(out_last), 32'(q_l[0]));
          if (out_ready) begin
            void'(q_p.pop_front()); void'(q_t.pop_front()); void'(q_l.pop_front());
          end
        end
      end
      if (out_valid6) begin
        if (q6_p.size() == 0) begin
          cmp("out_valid6_unexpected", 32'(out_valid6), 32'd0);
        end else begin
          p = q6_p[0];
          for (int i = 0; i < int'(W); i++)
            cmp($sformatf("psum6[%0d]", i), 32'(out_psum6[i*6 +: 6]), p[i*32 +: 32] & 32'h3F);
          cmp("total6", 32'(out_total6), q6_t[0] & 32'h3F);
          cmp("last6", 32'(out_last6), 32'(q6_l[0]));
          if (out_ready) begin
            void'(q6_p.pop_front()); void'(q6_t.pop_front()); void'(q6_l.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        model_beat(in_mask, in_mode, in_last, m_carry, p, t);
        q_p.push_back(p); q_t.push_back(t); q_l.push_back(in_last);
        acc = 1'b1;
      end
      if (in_valid && in_ready6) begin
        model_beat(in_mask, in_mode, in_last, m_carry6, p, t);
        q6_p.push_back(p); q6_t.push_back(t); q6_l.push_back(in_last);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] m, input logic md, input logic ls);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_mask  = m;
    in_mode  = md;
    in_last  = ls;
    do begin
      step();
      n++;
    end while (!acc && n < 50);
    cmp("send_accepted", 32'(acc), 32'd1);
  endtask

  // Returns the number of edges until out_valid is seen.
  task automatic wait_out(output int n);
    n        = 0;
    in_valid = 1'b0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    cmp("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int n;
    n         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q_p.size() != 0 || q6_p.size() != 0 || out_valid) && n < 100) begin
      step();
      n++;
    end
    cmp("drain_q", 32'(q_p.size()), 32'd0);
    cmp("drain_q6", 32'(q6_p.size()), 32'd0);
  endtask

  int lat;
  int t1_lane[8] = '{0, 1, 3, 4, 13, 19, 27, 31};
  int t1_val[8]  = '{1, 2, 2, 3, 4, 5, 6, 6};
  int t2_lane[5] = '{0, 1, 2, 5, 31};
  int t2_val[5]  = '{0, 1, 2, 3, 6};

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_mask = '0; in_mode = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    cmp("rst_in_ready", 32'(in_ready), 32'd1);
    cmp("rst_out_valid", 32'(out_valid), 32'd0);
    cmp("rst_total", out_total, 32'd0);
    cmp("rst_psum0", out_psum[31:0], 32'd0);
    cmp("rst_psum31", out_psum[31*32 +: 32], 32'd0);
    cmp("rst_last", 32'(out_last), 32'd0);

    // Single inclusive beat and its latency.
    send(32'h0808_2013, 1'b0, 1'b1);
    wait_out(lat);
    cmp("latency", lat, 32'd6);
    for (int k = 0; k < 8; k++)
      cmp($sformatf("t1_psum[%0d]", t1_lane[k]), out_psum[t1_lane[k]*32 +: 32], t1_val[k]);
    cmp("t1_total", out_total, 32'd6);
    drain();

    // Inclusive then exclusive back-to-back.
    send(32'h0808_2013, 1'b0, 1'b1);
    send(32'h0808_2013, 1'b1, 1'b1);
    wait_out(lat);
    step();
    cmp("b2b_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++)
      cmp($sformatf("t2_psum[%0d]", t2_lane[k]), out_psum[t2_lane[k]*32 +: 32], t2_val[k]);
    cmp("t2_total", out_total, 32'd6);
    drain();

    // Running carry over a packet.
    send(32'h0808_2013, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 1'b0, 1'b1);
    send(32'h0000_0001, 1'b0, 1'b1);
    wait_out(lat);
    step();
`ifdef PREFIX_CARRY_EN
    cmp("t3_psum0", out_psum[31:0], 32'd7);
    cmp("t3_psum31", out_psum[31*32 +: 32], 32'd38);
    cmp("t3_total", out_total, 32'd38);
`else
    cmp("t3_psum0", out_psum[31:0], 32'd1);
    cmp("t3_psum31", out_psum[31*32 +: 32], 32'd32);
    cmp("t3_total", out_total, 32'd32);
`endif
    step();
    cmp("t3b_psum0", out_psum[31:0], 32'd1);
    cmp("t3b_total", out_total, 32'd1);
    drain();

    // Wrap on the 6-bit instance.
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'h0000_0000, 1'b0, 1'b1);
    wait_out(lat);
    cmp("wrap_total6", 32'(out_total6), 32'd32);
    step();
`ifdef PREFIX_CARRY_EN
    cmp("wrap_psum6_31", 32'(out_psum6[31*6 +: 6]), 32'd0);
    cmp("wrap_psum6_0", 32'(out_psum6[5:0]), 32'd33);
`else
    cmp("wrap_psum6_31", 32'(out_psum6[31*6 +: 6]), 32'd32);
    cmp("wrap_psum6_0", 32'(out_psum6[5:0]), 32'd1);
`endif
    drain();

    // Backpressure: fill, stall with a beat waiting at the input, then release.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send($urandom, 1'($urandom_range(0, 1)), 1'(k == 4));
    wait_out(lat);
    in_valid = 1'b1;
    in_mask  = 32'h00F0_00F0;
    in_mode  = 1'b0;
    in_last  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      cmp("stall_no_accept", 32'(acc), 32'd0);
    end
    out_ready = 1'b1;
    do step(); while (!acc && out_valid);
    cmp("stall_accept", 32'(acc), 32'd1);
    drain();

    // Reset in mid-packet.
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    in_mask = 32'h0000_0001;
    in_last = 1'b1;
    reset   = 1'b1;
    step();
    reset = 1'b0;
    send(32'h0000_0001, 1'b0, 1'b1);
    wait_out(lat);
    cmp("rst_mid_psum0", out_psum[31:0], 32'd1);
    cmp("rst_mid_total", out_total, 32'd1);
    drain();

    // Randomised traffic with random backpressure; held beats stay stable until taken.
    for (int k = 0; k < 400; k++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0:       in_mask = '0;
          1:       in_mask = '1;
          default: in_mask = $urandom;
        endcase
        in_mode = 1'($urandom_range(0, 1));
        in_last = ($urandom_range(0, 3) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/mask_prefix_pipe.md
# mask_prefix_pipe

Pipelined, parametrised prefix-popcount unit for the redundancy controller. It takes a WIDTH-bit occupancy mask per beat and emits, for every lane, the number of set mask bits up to that lane (inclusive or exclusive per beat), plus the beat total. Its outputs are the compaction and scatter indices for downstream zero-skipping logic. It generalises the fixed 32-lane combinational Ladner-Fischer adder with:
- a registered tree pipeline and valid/ready handshake,
- per-beat inclusive/exclusive mode,
- a running carry across the multi-beat packets.

## Interface
- WIDTH, 32, mask lanes; power of 2, 4..256; LEVELS = log2(WIDTH) is derived internally.
- PSUM_W, 32, width of each lane sum and of total; must be ≥ LEVELS+1; all sums are modulo 2^PSUM_W.
- clk  in  1  single clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input beat present.
- in_ready  out  1  unit accepts the beat this cycle.
- in_mask  in  WIDTH  occupancy mask; bit i belongs to lane i.
- in_mode  in  1  0 = inclusive, 1 = exclusive prefix.
- in_last  in  1  final beat of a packet.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the output beat.
- out_psum  out  WIDTH*PSUM_W  lane i occupies bits [i*PSUM_W +: PSUM_W].
- out_total  out  PSUM_W  carry-in + popcount(in_mask).
- out_last  out  1  in_last of this beat.

## Operation
- **Pipeline structure**
  - LEVELS prefix-tree stages (Ladner-Fischer or Kogge-Stone; the choice is free), one register rank per level, then one output stage. The output stage holds the carry and drives the out_* registers.
  - The mask, mode and last bits travel with each beat through every rank.
- **Lane results**, with carry C = the carry value when the beat enters the output stage:
  - Inclusive: psum[i] = C + popcount(mask[i:0]).
  - Exclusive: psum[i] = C + popcount(mask[i-1:0]); psum[0] = C.
  - out_total = C + popcount(mask), independent of mode.
- **Carry update**: when a beat loads into the output stage, carry becomes 0 if last = 1, otherwise C + popcount(mask), taken modulo 2^PSUM_W.
- **Flow control**
  - Global stall enable: adv = !out_valid || out_ready.
  - in_ready = adv && !reset.
  - All ranks and the carry advance only when adv = 1.
  - Bubbles (valid = 0) propagate and never update the carry.
- **Reset** (synchronous)
  - Clears all stage valid bits, the carry, out_valid, out_psum, out_total and out_last to 0.
  - In-flight beats are discarded.
  - A reset in mid-packet starts the next beat with C = 0.
- **Wrap-around**: all additions truncate to PSUM_W bits; there is no saturation and no overflow flag.

## Timing
- Latency: a beat accepted at edge k gives out_valid = 1 after edge k+LEVELS+1 (6 cycles for WIDTH = 32). The pipeline is full-rate with no stalls.
- While out_valid && !out_ready:
  - all outputs hold stable,
  - in_ready = 0,
  - no pipeline rank or the carry changes.
- When out_ready = 1 and a new beat reaches the output stage in the same cycle, the output is replaced back-to-back with no bubble.
- in_valid = 1 while in_ready = 0 is legal; the beat is not taken, and the source must hold it.
- Outputs after reset deassertion: out_valid = 0, all data 0, in_ready = 1 on the first cycle.

## Configuration
- PREFIX_CARRY_EN defined:
  - the carry register and cross-beat accumulation are built as described above;
  - in_last clears the carry.
- PREFIX_CARRY_EN undefined:
  - C is constantly 0 and no carry register exists;
  - every beat is independent;
  - in_last is only passed through to out_last.

## Test plan
- **Single beat, inclusive**: WIDTH = 32, mask = 0x0808_2013 (bits 0, 1, 4, 13, 19, 27), mode = 0, last = 1 -> after 6 cycles psum[0] = 1, psum[1] = 2, psum[3] = 2, psum[4] = 3, psum[13] = 4, psum[19] = 5, psum[27] = 6, psum[31] = 6, total = 6.
- **Exclusive**: same mask with mode = 0, then mode = 1 back-to-back -> the exclusive beat gives psum[0] = 0, psum[1] = 1, psum[2] = 2, psum[5] = 3, psum[31] = 6. Outputs appear on consecutive cycles.
- **Carry** (PREFIX_CARRY_EN), three beats:
  - beat 1: 0x0808_2013, last = 0;
  - beat 2: 0xFFFF_FFFF, inclusive, last = 1 -> psum[0] = 7, psum[31] = 38, total = 38;
  - beat 3: 0x0000_0001, last = 1 -> psum[0] = 1, total = 1 (carry cleared).
  - With the macro undefined, beat 2 gives psum[31] = 32 instead.
- **Backpressure**: pipeline full, out_ready held 0 for 3 cycles -> in_ready = 0 and outputs unchanged. On release, all beats emerge in order with none lost or duplicated.
- **Wrap**: PSUM_W = 6, two all-ones beats with last = 0 -> beat 1 total = 32; beat 2 psum[31] = 0 (64 mod 64), psum[0] = 33.
- **Reset mid-packet**: one beat 0xFFFF_FFFF with last = 0, reset pulsed during the next beat, then mask 0x1 -> nothing emerges from before reset, and the new beat gives psum[0] = 1, total = 1.
